// File: rtl/tinyml_pkg.sv
// rtl/tinyml_pkg.sv - shared tile geometry and tile_load_packer FSM state type
package tinyml_pkg;

  typedef enum logic [1:0] {
    TLP_IDLE,
    TLP_FILL,
    TLP_LAST_WR,
    TLP_DONE
  } tlp_state_t;

  // The packer and the buffer file both derive their tile geometry from these.
  localparam int TILE_DATA_WIDTH = 8;
  localparam int TILE_ELEMS      = 32;
  localparam int TILE_BITS       = TILE_DATA_WIDTH * TILE_ELEMS;

endpackage

// File: rtl/tile_assembler.sv
// rtl/tile_assembler.sv - lane-indexed element insert into a tile register with clear
module tile_assembler #(
  parameter  int DATA_WIDTH = 8,
  parameter  int TILE_SIZE  = 32,
  localparam int LANE_W     = $clog2(TILE_SIZE),
  localparam int TILE_WIDTH = DATA_WIDTH * TILE_SIZE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  insert,
  input  logic [LANE_W-1:0]     lane,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [TILE_WIDTH-1:0] merged
);

  logic [TILE_WIDTH-1:0] tile_q;

  // Lane 0 occupies the LSBs, matching the buffer file's read unpacking.
  always_comb begin
    merged = tile_q;
    if (insert) begin
      merged[lane*DATA_WIDTH +: DATA_WIDTH] = data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tile_q <= '0;
    end else if (clear) begin
      tile_q <= '0;
    end else if (insert) begin
      tile_q <= merged;
    end
  end

endmodule

// File: rtl/tile_load_packer.sv
// rtl/tile_load_packer.sv - packs a byte stream into tiles for the tile buffer file
// Optional stall counter port enabled by TILE_LOAD_PACKER_PERF_EN.
module tile_load_packer
  import tinyml_pkg::*;
#(
  parameter  int DATA_WIDTH   = TILE_DATA_WIDTH,
  parameter  int TILE_SIZE    = TILE_ELEMS,
  parameter  int TILE_WIDTH   = TILE_BITS,
  parameter  int BUFFER_COUNT = 2,
  parameter  int MAX_LEN      = 1024,
  localparam int LEN_W        = $clog2(MAX_LEN + 1),
  localparam int BUF_W        = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1,
  localparam int LANE_W       = $clog2(TILE_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BUF_W-1:0]      dest_buffer,
  input  logic [LEN_W-1:0]      length,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  write_enable,
  output logic [TILE_WIDTH-1:0] write_data,
  output logic [BUF_W-1:0]      write_buffer,
  output logic                  reset_indices_enable,
  output logic [BUF_W-1:0]      reset_indices_buffer,
  output logic                  busy,
  output logic                  done
`ifdef TILE_LOAD_PACKER_PERF_EN
  ,
  output logic [15:0]           stall_cycles
`endif
);

  tlp_state_t state, state_nxt;

  logic                  start_acc, accept, last_elem, tile_done;
  logic [LEN_W-1:0]      len_in, length_q, elem_cnt;
  logic [LANE_W-1:0]     lane_cnt;
  logic [BUF_W-1:0]      buffer_q;
  logic                  first_tile;
  logic [TILE_WIDTH-1:0] merged;

  assign len_in    = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
  assign start_acc = (state == TLP_IDLE) && start;
  assign in_ready  = (state == TLP_FILL);
  assign accept    = in_valid && in_ready;
  assign last_elem = (elem_cnt == length_q - LEN_W'(1));
  assign tile_done = accept && ((lane_cnt == LANE_W'(TILE_SIZE - 1)) || last_elem);

  assign busy                 = (state == TLP_FILL) || (state == TLP_LAST_WR);
  assign done                 = (state == TLP_DONE);
  assign write_buffer         = buffer_q;
  assign reset_indices_buffer = buffer_q;
  // The buffer file only honours an index reset alongside a write.
  assign reset_indices_enable = write_enable && first_tile;

  tile_assembler #(
    .DATA_WIDTH (DATA_WIDTH),
    .TILE_SIZE  (TILE_SIZE)
  ) u_assembler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tile_done || start_acc),
    .insert  (accept),
    .lane    (lane_cnt),
    .data    (in_data),
    .merged  (merged)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      TLP_IDLE:    if (start) state_nxt = (len_in == '0) ? TLP_DONE : TLP_FILL;
      TLP_FILL:    if (accept && last_elem) state_nxt = TLP_LAST_WR;
      TLP_LAST_WR: state_nxt = TLP_DONE;
      TLP_DONE:    state_nxt = TLP_IDLE;
      default:     state_nxt = TLP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= TLP_IDLE;
      length_q     <= '0;
      buffer_q     <= '0;
      elem_cnt     <= '0;
      lane_cnt     <= '0;
      first_tile   <= 1'b0;
      write_enable <= 1'b0;
      write_data   <= '0;
    end else begin
      state        <= state_nxt;
      write_enable <= tile_done;
      if (start_acc) begin
        length_q   <= len_in;
        buffer_q   <= dest_buffer;
        elem_cnt   <= '0;
        lane_cnt   <= '0;
        first_tile <= 1'b1;
      end else begin
        if (write_enable) first_tile <= 1'b0;
        if (accept) begin
          elem_cnt <= elem_cnt + LEN_W'(1);
          lane_cnt <= tile_done ? '0 : lane_cnt + LANE_W'(1);
        end
      end
      if (tile_done) write_data <= merged;
    end
  end

`ifdef TILE_LOAD_PACKER_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (start_acc) begin
      stall_cycles <= '0;
    end else if ((state == TLP_FILL) && !in_valid && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tile_load_packer.sv
// tb/tb_tile_load_packer.sv - self-checking bench for tile_load_packer with a tile scoreboard
module tb_tile_load_packer;

  localparam int TS = 32;
  localparam int TW = 256;

  typedef struct packed {
    logic [TW-1:0] data;
    logic          bsel;
    logic          first;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          dest_buffer = 1'b0;
  logic [10:0]   length = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready, write_enable, write_buffer;
  logic [TW-1:0] write_data;
  logic          reset_indices_enable, reset_indices_buffer, busy, done;
`ifdef TILE_LOAD_PACKER_PERF_EN
  logic [15:0]   stall_cycles;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cyc = -1;
  int   we_n = 0;
  int   we_cyc[$];
  bit   busy_seen = 1'b0;
  int   start_cyc, last_cyc, gaps;
  exp_t sb[$];
  logic [7:0] bytes [1024];

  always #5 clk = ~clk;

  tile_load_packer dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start                (start),
    .dest_buffer          (dest_buffer),
    .length               (length),
    .in_valid             (in_valid),
    .in_data              (in_data),
    .in_ready             (in_ready),
    .write_enable         (write_enable),
    .write_data           (write_data),
    .write_buffer         (write_buffer),
    .reset_indices_enable (reset_indices_enable),
    .reset_indices_buffer (reset_indices_buffer),
    .busy                 (busy),
    .done                 (done)
`ifdef TILE_LOAD_PACKER_PERF_EN
    ,
    .stall_cycles         (stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (busy) busy_seen = 1'b1;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (reset_indices_enable && !write_enable) check("rie_without_write", 1, 0);
        if (write_enable) begin
          we_n++;
          we_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = sb.pop_front();
            check("tile_data", write_data, e.data);
            check("write_buffer", write_buffer, e.bsel);
            check("reset_idx_en", reset_indices_enable, e.first);
            check("reset_idx_buf", reset_indices_buffer, e.bsel);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check(tag, {in_ready, write_enable, write_buffer, reset_indices_enable,
                reset_indices_buffer, busy, done}, 0);
    check({tag, "_wdata"}, write_data, 0);
`ifdef TILE_LOAD_PACKER_PERF_EN
    check({tag, "_stall"}, stall_cycles, 0);
`endif
  endtask

  task automatic run_load(input int bsel, input int len_cmd, input int gap_pct,
                          input int mid_at, input int abort_at, input bit seq);
    int   eff, ntiles, n, g;
    exp_t e;
    eff    = (len_cmd > 1024) ? 1024 : len_cmd;
    ntiles = (eff + TS - 1) / TS;
    for (int i = 0; i < eff; i++) bytes[i] = seq ? 8'(i + 1) : 8'($urandom);
    for (int k = 0; k < ntiles; k++) begin
      e.data = '0;
      for (int j = 0; j < TS; j++)
        if (k * TS + j < eff) e.data[j*8 +: 8] = bytes[k*TS + j];
      e.bsel  = 1'(bsel);
      e.first = (k == 0);
      sb.push_back(e);
    end
    done_cyc = -1; we_n = 0; we_cyc.delete(); busy_seen = 1'b0; gaps = 0;

    @(posedge clk); #1;
    start = 1'b1; dest_buffer = 1'(bsel); length = 11'(len_cmd);
    @(posedge clk); start_cyc = cyc; #1;
    start = 1'b0; dest_buffer = 1'b0; length = '0;

    for (int i = 0; i < eff; i++) begin
      if (i == abort_at) begin
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_reset_outputs("abort_outputs");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        return;
      end
      g = 0;
      while (gap_pct > 0 && g < 8 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        gaps++; g++;
      end
      in_valid = 1'b1;
      in_data  = bytes[i];
      if (i == mid_at) begin
        start = 1'b1; dest_buffer = ~1'(bsel); length = 11'd5;
      end
      n = 0;
      while (!in_ready && n < 100) begin
        @(posedge clk); #1; n++;
      end
      if (n >= 100) check("in_ready_timeout", 0, 1);
      @(posedge clk); last_cyc = cyc; #1;
      start = 1'b0; dest_buffer = 1'b0; length = '0;
    end
    in_valid = 1'b0;

    for (n = 0; n < 60 && done_cyc < 0; n++) @(posedge clk);
    #1;
    check("done_seen", (done_cyc >= 0), 1);
    if (eff > 0) begin
      check("done_latency", done_cyc, last_cyc + 1);
      if (we_cyc.size() > 0) check("final_we_latency", we_cyc[$], last_cyc);
    end else begin
      check("zero_len_done", done_cyc, start_cyc);
    end
    check("tiles_written", we_n, ntiles);
    check("scoreboard_empty", sb.size(), 0);
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Two full tiles into buffer 1, continuous valid.
    run_load(1, 64, 0, -1, -1, 1'b0);
    check("two_tile_spacing", (we_cyc.size() == 2) ? we_cyc[1] - we_cyc[0] : -1, 32);
    check("busy_seen_full", busy_seen, 1);

    // Partial second tile is zero padded above lane 7.
    run_load(0, 40, 0, -1, -1, 1'b1);

    // Zero-length load.
    run_load(1, 0, 0, -1, -1, 1'b0);
    check("zero_len_busy", busy_seen, 0);

    // Random valid gaps.
    run_load(0, 32, 30, -1, -1, 1'b0);
`ifdef TILE_LOAD_PACKER_PERF_EN
    check("stall_cycles", stall_cycles, gaps);
`endif

    // Start pulsed mid-load is ignored.
    run_load(0, 64, 0, 10, -1, 1'b0);

    // Length above MAX_LEN clamps to 1024 elements (32 tiles).
    run_load(1, 2000, 0, -1, -1, 1'b0);

    // Asynchronous reset mid-tile, then a clean single-tile load.
    run_load(1, 32, 0, -1, 17, 1'b0);
    repeat (2) @(posedge clk); #1;
    run_load(0, 32, 0, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
